// File: rtl/rps_pkg.sv
// rps_pkg: shared encodings for the rock-paper-scissors game sequencer.
//   state_e   : game phase (READY/COUNTDOWN/WAITING/RESULT), 2-bit encoded
//   HAND_*    : hand codes (NONE/ROCK/PAPER/SCISSORS)
//   RES_*     : outcome codes from the player's point of view
//   judge()   : outcome of a player hand against the computer hand
package rps_pkg;

  typedef enum logic [1:0] {
    ST_READY     = 2'b00,
    ST_COUNTDOWN = 2'b01,
    ST_WAITING   = 2'b10,
    ST_RESULT    = 2'b11
  } state_e;

  localparam logic [1:0] HAND_NONE     = 2'b00;
  localparam logic [1:0] HAND_ROCK     = 2'b01;
  localparam logic [1:0] HAND_PAPER    = 2'b10;
  localparam logic [1:0] HAND_SCISSORS = 2'b11;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_LOSE = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  // Both hands are expected to be non-NONE when this is called.
  function automatic logic [1:0] judge(input logic [1:0] player, input logic [1:0] com);
    logic [1:0] res;
    if (player == com) begin
      res = RES_DRAW;
    end else if ((player == HAND_ROCK     && com == HAND_SCISSORS) ||
                 (player == HAND_PAPER    && com == HAND_ROCK)     ||
                 (player == HAND_SCISSORS && com == HAND_PAPER)) begin
      res = RES_WIN;
    end else begin
      res = RES_LOSE;
    end
    return res;
  endfunction

endpackage

// File: rtl/rps_game_ctrl_if.sv
// rps_game_ctrl_if: player-side controls and sprite-select outputs of the game.
//   btn_start   start/rematch pulse          play_valid  player move strobe
//   play_sel    player move code             state       game phase
//   com_hand    computer hand                player_hand player hand
//   result      outcome                      cd_digit    countdown digit
//   wins/losses saturating score
// master: drives the buttons and observes the game; slave: the game controller.
interface rps_game_ctrl_if;
  logic       btn_start;
  logic       play_valid;
  logic [1:0] play_sel;
  logic [1:0] state;
  logic [1:0] com_hand;
  logic [1:0] player_hand;
  logic [1:0] result;
  logic [1:0] cd_digit;
  logic [3:0] wins;
  logic [3:0] losses;

  modport master (
    output btn_start, play_valid, play_sel,
    input  state, com_hand, player_hand, result, cd_digit, wins, losses
  );

  modport slave (
    input  btn_start, play_valid, play_sel,
    output state, com_hand, player_hand, result, cd_digit, wins, losses
  );
endinterface

// File: rtl/rps_hand_gen.sv
// rps_hand_gen: computer hand source, produces a non-NONE hand every cycle.
//   clk     system clock
//   rst     asynchronous active-low reset
//   hand_o  current computer hand candidate
// Build option RPS_LFSR_EN: 16-bit Fibonacci LFSR (taps 16,14,13,11, seed
// 16'hACE1), hand from lfsr[1:0]; otherwise a ROCK->PAPER->SCISSORS rotor.
module rps_hand_gen
  import rps_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] hand_o
);

`ifdef RPS_LFSR_EN
  logic [15:0] lfsr_q;
  logic        fb;

  assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 16'hACE1;
    else      lfsr_q <= {lfsr_q[14:0], fb};
  end

  // Code 11 folds onto ROCK so the output is never NONE.
  always_comb begin
    hand_o = HAND_ROCK;
    case (lfsr_q[1:0])
      2'b00:   hand_o = HAND_ROCK;
      2'b01:   hand_o = HAND_PAPER;
      2'b10:   hand_o = HAND_SCISSORS;
      default: hand_o = HAND_ROCK;
    endcase
  end
`else
  logic [1:0] hand_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hand_q <= HAND_ROCK;
    end else begin
      case (hand_q)
        HAND_ROCK:  hand_q <= HAND_PAPER;
        HAND_PAPER: hand_q <= HAND_SCISSORS;
        default:    hand_q <= HAND_ROCK;
      endcase
    end
  end

  assign hand_o = hand_q;
`endif

endmodule

// File: rtl/rps_game_ctrl.sv
// rps_game_ctrl: rock-paper-scissors sequencer feeding the VGA address generator.
//   clk   system clock (100 MHz)
//   rst   asynchronous active-low reset
//   bus   rps_game_ctrl_if.slave: btn_start/play_valid/play_sel in;
//         state/com_hand/player_hand/result/cd_digit/wins/losses out (all registered)
// Build option RPS_LFSR_EN selects the computer hand source inside rps_hand_gen.
module rps_game_ctrl
  import rps_pkg::*;
#(
  parameter int unsigned CNT_W         = 29,
  parameter int unsigned CD_STEP       = 50_000_000,
  parameter int unsigned WAIT_CYCLES   = 200_000_000,
  parameter int unsigned RESULT_CYCLES = 250_000_000
) (
  input logic              clk,
  input logic              rst,
  rps_game_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] CD_2_AT   = CNT_W'(CD_STEP);
  localparam logic [CNT_W-1:0] CD_1_AT   = CNT_W'(2 * CD_STEP);
  localparam logic [CNT_W-1:0] CD_LAST   = CNT_W'(3 * CD_STEP - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RES_LAST  = CNT_W'(RESULT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
  logic [1:0]       cd_q, cd_d;
  logic [1:0]       com_q, com_d;
  logic [1:0]       player_q, player_d;
  logic [1:0]       result_q, result_d;
  logic [3:0]       wins_q, wins_d;
  logic [3:0]       losses_q, losses_d;
  logic [1:0]       outcome;
  logic [1:0]       gen_hand;
  logic             move_ok;

  rps_hand_gen u_hand_gen (
    .clk    (clk),
    .rst    (rst),
    .hand_o (gen_hand)
  );

  assign timer_inc = timer_q + 1'b1;
  assign move_ok   = bus.play_valid && (bus.play_sel != HAND_NONE);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cd_d     = cd_q;
    com_d    = com_q;
    player_d = player_q;
    result_d = result_q;
    outcome  = RES_NONE;

    case (state_q)
      ST_READY: begin
        if (bus.btn_start) begin
          state_d  = ST_COUNTDOWN;
          timer_d  = '0;
          cd_d     = 2'd3;
          com_d    = HAND_NONE;
          player_d = HAND_NONE;
          result_d = RES_NONE;
        end
      end

      ST_COUNTDOWN: begin
        if (timer_q == CD_LAST) begin
          state_d = ST_WAITING;
          timer_d = '0;
          cd_d    = '0;
          com_d   = gen_hand;
        end else begin
          timer_d = timer_inc;
          // Digit is derived from the incremented count so it stays aligned
          // with the registered timer value.
          if (timer_inc < CD_2_AT)      cd_d = 2'd3;
          else if (timer_inc < CD_1_AT) cd_d = 2'd2;
          else                          cd_d = 2'd1;
        end
      end

      ST_WAITING: begin
        // A valid move takes priority over a simultaneous timeout.
        if (move_ok) begin
          state_d  = ST_RESULT;
          timer_d  = '0;
          player_d = bus.play_sel;
          outcome  = judge(bus.play_sel, com_q);
          result_d = outcome;
        end else if (timer_q == WAIT_LAST) begin
          state_d  = ST_RESULT;
          timer_d  = '0;
          player_d = HAND_NONE;
          outcome  = RES_LOSE;
          result_d = RES_LOSE;
        end else begin
          timer_d = timer_inc;
        end
      end

      ST_RESULT: begin
        if (bus.btn_start) begin
          state_d  = ST_COUNTDOWN;
          timer_d  = '0;
          cd_d     = 2'd3;
          com_d    = HAND_NONE;
          player_d = HAND_NONE;
          result_d = RES_NONE;
        end else if (timer_q == RES_LAST) begin
          state_d  = ST_READY;
          timer_d  = '0;
          com_d    = HAND_NONE;
          player_d = HAND_NONE;
          result_d = RES_NONE;
        end else begin
          timer_d = timer_inc;
        end
      end

      default: state_d = ST_READY;
    endcase

    wins_d   = wins_q;
    losses_d = losses_q;
    if (outcome == RES_WIN  && wins_q   != 4'hF) wins_d   = wins_q + 4'd1;
    if (outcome == RES_LOSE && losses_q != 4'hF) losses_d = losses_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_READY;
      timer_q  <= '0;
      cd_q     <= '0;
      com_q    <= HAND_NONE;
      player_q <= HAND_NONE;
      result_q <= RES_NONE;
      wins_q   <= '0;
      losses_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cd_q     <= cd_d;
      com_q    <= com_d;
      player_q <= player_d;
      result_q <= result_d;
      wins_q   <= wins_d;
      losses_q <= losses_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.com_hand    = com_q;
  assign bus.player_hand = player_q;
  assign bus.result      = result_q;
  assign bus.cd_digit    = cd_q;
  assign bus.wins        = wins_q;
  assign bus.losses      = losses_q;

endmodule

// File: tb/tb_rps_game_ctrl.sv
// tb_rps_game_ctrl: directed bench for rps_game_ctrl with short phase timings
// (CD_STEP=4, WAIT_CYCLES=20, RESULT_CYCLES=10). A small reference of the
// computer hand source predicts which hand is latched at the end of countdown.
module tb_rps_game_ctrl;
  import rps_pkg::*;

  localparam int unsigned CD_STEP       = 4;
  localparam int unsigned WAIT_CYCLES   = 20;
  localparam int unsigned RESULT_CYCLES = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rps_game_ctrl_if bus ();

  rps_game_ctrl #(
    .CNT_W         (29),
    .CD_STEP       (CD_STEP),
    .WAIT_CYCLES   (WAIT_CYCLES),
    .RESULT_CYCLES (RESULT_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned exp_wins = 0;
  int unsigned exp_losses = 0;

  // Reference computer-hand source; *_prev holds the value seen before the
  // most recent edge, which is what the controller latches on that edge.
`ifdef RPS_LFSR_EN
  logic [15:0] m_lfsr, m_lfsr_prev;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lfsr      <= 16'hACE1;
      m_lfsr_prev <= 16'hACE1;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    end
  end
  function automatic logic [1:0] lfsr_hand(input logic [15:0] l);
    logic [1:0] low;
    low = l[1:0];
    if (low == 2'b01)      return HAND_PAPER;
    else if (low == 2'b10) return HAND_SCISSORS;
    else                   return HAND_ROCK;
  endfunction
  function automatic logic [1:0] model_cur();
    return lfsr_hand(m_lfsr);
  endfunction
  function automatic logic [1:0] model_latched();
    return lfsr_hand(m_lfsr_prev);
  endfunction
`else
  int unsigned m_idx, m_idx_prev;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_idx      <= 0;
      m_idx_prev <= 0;
    end else begin
      m_idx_prev <= m_idx;
      m_idx      <= (m_idx + 1) % 3;
    end
  end
  function automatic logic [1:0] model_cur();
    return 2'(m_idx + 1);
  endfunction
  function automatic logic [1:0] model_latched();
    return 2'(m_idx_prev + 1);
  endfunction
`endif

  function automatic logic [1:0] beats(input logic [1:0] h);
    if (h == HAND_ROCK)       return HAND_PAPER;
    else if (h == HAND_PAPER) return HAND_SCISSORS;
    else                      return HAND_ROCK;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_state"},  32'(bus.state),       32'(ST_READY));
    check_eq({tag, "_com"},    32'(bus.com_hand),    32'(HAND_NONE));
    check_eq({tag, "_player"}, 32'(bus.player_hand), 32'(HAND_NONE));
    check_eq({tag, "_result"}, 32'(bus.result),      32'(RES_NONE));
    check_eq({tag, "_cd"},     32'(bus.cd_digit),    32'd0);
    check_eq({tag, "_wins"},   32'(bus.wins),        32'(exp_wins));
    check_eq({tag, "_losses"}, 32'(bus.losses),      32'(exp_losses));
  endtask

  // Press start, run the countdown, stop one sample after entering WAITING.
  task automatic start_round(input bit full, output logic [1:0] com);
    bus.btn_start = 1'b1;
    tick();
    bus.btn_start = 1'b0;
    check_eq("start_state", 32'(bus.state), 32'(ST_COUNTDOWN));
    check_eq("start_cd", 32'(bus.cd_digit), 32'd3);
    check_eq("start_result", 32'(bus.result), 32'(RES_NONE));
    for (int k = 1; k < 12; k++) begin
      if (full && k == 5) begin
        bus.play_valid = 1'b1;
        bus.play_sel   = HAND_PAPER;
      end
      tick();
      bus.play_valid = 1'b0;
      bus.play_sel   = HAND_NONE;
      if (full) check_eq($sformatf("cd_%0d", k), 32'(bus.cd_digit), 32'(3 - k / 4));
    end
    tick();
    com = model_latched();
    check_eq("wait_state", 32'(bus.state), 32'(ST_WAITING));
    check_eq("wait_cd", 32'(bus.cd_digit), 32'd0);
    check_eq("wait_com", 32'(bus.com_hand), 32'(com));
    if (full) begin
      check_eq("wait_com_nonzero", 32'(bus.com_hand != HAND_NONE), 32'd1);
      check_eq("wait_player_none", 32'(bus.player_hand), 32'(HAND_NONE));
    end
  endtask

  task automatic play(input string tag, input logic [1:0] sel, input logic [1:0] res);
    bus.play_valid = 1'b1;
    bus.play_sel   = sel;
    tick();
    bus.play_valid = 1'b0;
    bus.play_sel   = HAND_NONE;
    if (res == RES_WIN  && exp_wins   < 15) exp_wins++;
    if (res == RES_LOSE && exp_losses < 15) exp_losses++;
    check_eq({tag, "_state"},  32'(bus.state),       32'(ST_RESULT));
    check_eq({tag, "_player"}, 32'(bus.player_hand), 32'(sel));
    check_eq({tag, "_result"}, 32'(bus.result),      32'(res));
    check_eq({tag, "_wins"},   32'(bus.wins),        32'(exp_wins));
    check_eq({tag, "_losses"}, 32'(bus.losses),      32'(exp_losses));
  endtask

  // Counter build: latched hand equals the source value at press time.
  task automatic align_rock();
`ifndef RPS_LFSR_EN
    for (int n = 0; n < 3 && model_cur() != HAND_ROCK; n++) tick();
`endif
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] com;
    bus.btn_start  = 1'b0;
    bus.play_valid = 1'b0;
    bus.play_sel   = HAND_NONE;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b1;
    tick();
    tick();

    // Countdown digits, then a winning move against a ROCK (counter build)
    align_rock();
    start_round(1'b1, com);
`ifndef RPS_LFSR_EN
    check_eq("t2_com_rock", 32'(com), 32'(HAND_ROCK));
`endif
    play("t2", beats(com), RES_WIN);

    // RESULT holds for RESULT_CYCLES, then clears back to READY
    repeat (RESULT_CYCLES - 1) tick();
    check_eq("t3_result_hold", 32'(bus.state), 32'(ST_RESULT));
    tick();
    check_idle("t3_ready_a");

    // Timeout with no move
    start_round(1'b0, com);
    repeat (WAIT_CYCLES - 1) tick();
    check_eq("t3_wait_last", 32'(bus.state), 32'(ST_WAITING));
    tick();
    exp_losses++;
    check_eq("t3_to_state",  32'(bus.state),       32'(ST_RESULT));
    check_eq("t3_to_player", 32'(bus.player_hand), 32'(HAND_NONE));
    check_eq("t3_to_result", 32'(bus.result),      32'(RES_LOSE));
    check_eq("t3_to_losses", 32'(bus.losses),      32'(exp_losses));
    repeat (RESULT_CYCLES) tick();
    check_idle("t3_ready_b");

    // Move on the timeout cycle wins over the timeout; equal hand -> DRAW
    start_round(1'b0, com);
    repeat (WAIT_CYCLES - 1) tick();
    check_eq("t4_wait_last", 32'(bus.state), 32'(ST_WAITING));
    play("t4", com, RES_DRAW);

    // 16 consecutive wins via rematch; score saturates
    for (int i = 0; i < 16; i++) begin
      start_round(1'b0, com);
      play($sformatf("t5_%0d", i), beats(com), RES_WIN);
    end
    check_eq("t5_wins_sat", 32'(bus.wins), 32'hF);

    // btn_start ignored in WAITING, then async reset mid-WAITING
    start_round(1'b0, com);
    tick();
    bus.btn_start = 1'b1;
    tick();
    bus.btn_start = 1'b0;
    check_eq("t6_start_in_wait", 32'(bus.state), 32'(ST_WAITING));
    check_eq("t6_cd_in_wait", 32'(bus.cd_digit), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    exp_wins   = 0;
    exp_losses = 0;
    check_idle("t6_async_rst");
    tick();
    #2;
    rst = 1'b1;
    tick();
    bus.play_valid = 1'b1;
    bus.play_sel   = HAND_ROCK;
    tick();
    bus.play_valid = 1'b0;
    bus.play_sel   = HAND_NONE;
    check_idle("t6_play_in_ready");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
